// File: rtl/prio_encoder_pkg.sv
// Shared types and helpers for the streaming priority/one-hot encoder.
// The one-hot test is width-generic by zero-padding up to ONEHOT_MAX_W bits.
package prio_encoder_pkg;

  typedef enum logic [1:0] {
    ENC_STRICT  = 2'b00,
    ENC_PRIO_HI = 2'b01,
    ENC_PRIO_LO = 2'b10,
    ENC_RSVD    = 2'b11
  } enc_mode_e;

  localparam int ONEHOT_MAX_W = 256;

  // popcount == 1: non-zero and clearing the lowest set bit leaves nothing
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/prio_encoder_core.sv
// Combinational N-to-log2(N) encoder: STRICT one-hot, highest-set or lowest-set index.
// Illegal inputs for the selected mode give code 0 with err 1, never X.
module prio_encoder_core
  import prio_encoder_pkg::*;
#(
  parameter int N = 8,
  localparam int OUT_W = $clog2(N)
) (
  input  logic [N-1:0]     data,
  input  enc_mode_e        mode,
  output logic [OUT_W-1:0] code,
  output logic             err
);

  logic [ONEHOT_MAX_W-1:0] padded;
  logic [OUT_W-1:0]        hi_idx;
  logic [OUT_W-1:0]        lo_idx;
  logic                    any_set;
  logic                    onehot;

  always_comb begin
    padded         = '0;
    padded[N-1:0]  = data;
    any_set        = |data;
    onehot         = is_onehot(padded);
  end

  // Ascending scan keeps the last (highest) hit; descending keeps the lowest.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (data[i]) hi_idx = OUT_W'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (data[i]) lo_idx = OUT_W'(i);
    end
  end

  always_comb begin
    code = '0;
    err  = 1'b0;
    unique case (mode)
      ENC_PRIO_HI: begin
        code = any_set ? hi_idx : '0;
        err  = !any_set;
      end
      ENC_PRIO_LO: begin
        code = any_set ? lo_idx : '0;
        err  = !any_set;
      end
      default: begin
        // STRICT and the reserved encoding share behaviour
        code = onehot ? lo_idx : '0;
        err  = !onehot;
      end
    endcase
  end

endmodule

// File: rtl/prio_encoder_stream.sv
// Streaming encoder: valid/ready in, 2-entry result FIFO out, saturating error counter.
// Latency 1 cycle into an empty FIFO; in_ready is registered and drops once both entries are held.
module prio_encoder_stream
  import prio_encoder_pkg::*;
#(
  parameter int N = 8,
  parameter int ERR_CNT_W = 8,
  localparam int OUT_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_code,
  output logic                 out_err,
  input  logic                 clr_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [OUT_W-1:0] code;
    logic             err;
  } result_t;

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  result_t    res;
  result_t    head_q;
  result_t    tail_q;
  logic [1:0] count_q;
  logic [1:0] count_next;
  logic       push;
  logic       pop;

  prio_encoder_core #(
    .N (N)
  ) u_core (
    .data (in_data),
    .mode (enc_mode_e'(in_mode)),
    .code (res.code),
    .err  (res.err)
  );

  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_code  = out_valid ? head_q.code : '0;
  assign out_err   = out_valid ? head_q.err : 1'b0;

  always_comb begin
    count_next = count_q;
    unique case ({push, pop})
      2'b10:   count_next = count_q + 2'd1;
      2'b01:   count_next = count_q - 2'd1;
      default: count_next = count_q;
    endcase
  end

  // The new result lands in slot count_next-1; a pop first shifts tail to head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      count_q  <= count_next;
      in_ready <= (count_next < 2'd2);
      if (pop) head_q <= tail_q;
      if (push) begin
        if (count_next == 2'd1) head_q <= res;
        else                    tail_q <= res;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (push && res.err && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Directed and random stimulus for prio_encoder_stream against a queue-based reference model.
module tb_prio_encoder_stream;
  localparam int N     = 8;
  localparam int OUT_W = $clog2(N);
  localparam int EW    = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic [1:0]       in_mode = 2'b00;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_code;
  logic             out_err;
  logic             clr_err = 1'b0;
  logic [EW-1:0]    err_count;

  logic       in_valid4 = 1'b0;
  logic       in_ready4;
  logic [3:0] in_data4 = '0;
  logic [1:0] in_mode4 = 2'b00;
  logic       out_valid4;
  logic       out_ready4 = 1'b1;
  logic [1:0] out_code4;
  logic       out_err4;
  logic       clr_err4 = 1'b0;
  logic [1:0] err_count4;

  prio_encoder_stream #(.N(N), .ERR_CNT_W(EW)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_err(out_err),
    .clr_err(clr_err), .err_count(err_count)
  );

  prio_encoder_stream #(.N(4), .ERR_CNT_W(2)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_code(out_code4), .out_err(out_err4),
    .clr_err(clr_err4), .err_count(err_count4)
  );

  typedef struct {
    int code;
    bit err;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  bit   m_rdy = 1'b0;
  int   m_cnt = 0;
  int   popped[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: count set bits and note first/last positions, then apply the mode rules.
  function automatic res_t ref_enc(input logic [N-1:0] d, input logic [1:0] m);
    res_t r;
    int ones = 0;
    int hi = 0;
    int lo = -1;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        ones++;
        if (lo < 0) lo = i;
        hi = i;
      end
    end
    r.code = 0;
    r.err  = 1'b1;
    if (m == 2'b01 || m == 2'b10) begin
      if (ones > 0) begin
        r.code = (m == 2'b01) ? hi : lo;
        r.err  = 1'b0;
      end
    end else if (ones == 1) begin
      r.code = lo;
      r.err  = 1'b0;
    end
    return r;
  endfunction

  task automatic cycle();
    bit   push;
    bit   pop;
    res_t r;
    res_t gone;
    push = in_valid && m_rdy;
    pop  = (q.size() != 0) && out_ready;
    r    = ref_enc(in_data, in_mode);
    if (pop) popped.push_back(int'(out_code));
    @(posedge clk);
    #1;
    if (pop) gone = q.pop_front();
    if (push) q.push_back(r);
    if (clr_err) m_cnt = 0;
    else if (push && r.err && m_cnt < (2**EW - 1)) m_cnt++;
    m_rdy = (q.size() < 2);
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_code", out_code, (q.size() != 0) ? q[0].code : 0);
    chk("out_err", out_err, (q.size() != 0) ? q[0].err : 1'b0);
    chk("err_count", err_count, m_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int bp[3];
    int bp_idx;
    int exp4[5];
    bp   = '{4, 16, 64};
    exp4 = '{1, 2, 3, 3, 3};

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_count4", err_count4, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("in_ready_before_edge", in_ready, 0);
    cycle();

    // STRICT sweep plus two illegal inputs
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    for (int i = 0; i < N; i++) begin
      in_data = N'(1) << i;
      cycle();
      chk("strict_sweep_code", out_code, i);
    end
    in_data = 8'h00;
    cycle();
    in_data = 8'h81;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("strict_err_count", err_count, 2);

    // Priority modes on one pattern
    in_valid = 1'b1;
    in_data  = 8'b0101_0100;
    in_mode  = 2'b01;
    cycle();
    chk("prio_hi_code", out_code, 6);
    in_mode = 2'b10;
    cycle();
    chk("prio_lo_code", out_code, 2);
    in_mode = 2'b11;
    cycle();
    chk("rsvd_code", out_code, 0);
    chk("rsvd_err", out_err, 1);
    in_valid = 1'b0;
    cycle();

    // Backpressure: source advances only on acceptance
    out_ready = 1'b0;
    in_mode   = 2'b00;
    bp_idx    = 0;
    for (int c = 0; c < 4; c++) begin
      bit acc;
      in_valid = (bp_idx < 3);
      in_data  = N'(bp[bp_idx < 3 ? bp_idx : 2]);
      acc      = in_valid && m_rdy;
      cycle();
      if (acc) bp_idx++;
      if (c == 1) chk("bp_full_in_ready", in_ready, 0);
    end
    chk("bp_third_held", bp_idx, 2);
    popped.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bit acc;
      in_valid = (bp_idx < 3);
      in_data  = N'(bp[bp_idx < 3 ? bp_idx : 2]);
      acc      = in_valid && m_rdy;
      cycle();
      if (acc) bp_idx++;
    end
    chk("bp_pop_count", popped.size(), 3);
    for (int k = 0; k < 3; k++) chk("bp_order", (k < popped.size()) ? popped[k] : -1, 2 * (k + 1));

    // Randomized traffic
    for (int c = 0; c < 300; c++) begin
      int kind;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom % 4) != 0;
      in_mode   = 2'($urandom_range(0, 3));
      clr_err   = ($urandom % 16) == 0;
      kind      = $urandom_range(0, 2);
      if (kind == 0)      in_data = N'(1) << $urandom_range(0, N - 1);
      else if (kind == 1) in_data = '0;
      else                in_data = N'($urandom);
      cycle();
    end
    in_valid  = 1'b0;
    clr_err   = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    // Saturating counter on the small instance
    for (int k = 0; k < 5; k++) begin
      chk("cnt4_in_ready", in_ready4, 1);
      in_valid4 = 1'b1;
      @(posedge clk);
      #1;
      chk("cnt4_err_count", err_count4, exp4[k]);
      chk("cnt4_out_err", out_err4, 1);
      chk("cnt4_out_valid", out_valid4, 1);
    end
    clr_err4 = 1'b1;
    @(posedge clk);
    #1;
    chk("cnt4_clear_wins", err_count4, 0);
    in_valid4 = 1'b0;
    clr_err4  = 1'b0;
    @(posedge clk);
    #1;
    chk("cnt4_after_clear", err_count4, 0);

    // Reset mid-stream with a full FIFO
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_data   = 8'h08;
    cycle();
    in_data = 8'h20;
    cycle();
    in_valid = 1'b0;
    chk("mid_fifo_full", q.size(), 2);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_code", out_code, 0);
    chk("mid_rst_err_count", err_count, 0);
    #1;
    reset_n = 1'b1;
    q.delete();
    m_rdy     = 1'b0;
    m_cnt     = 0;
    out_ready = 1'b1;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_encoder_stream.md
# prio_encoder_stream

Parametrised N-to-log2(N) encoder with valid/ready streaming on both sides, runtime-selectable encoding mode, an explicit error flag instead of X outputs, and a saturating error counter. It is the generalised successor to the fixed 4-to-2 registered encoder. It sits between request/one-hot producers (arbiters, decoders, status vectors) and index consumers that may stall, buffering up to two results.

## Interface
- N, default 8: input vector width; legal N ≥ 2, power of two not required.
- OUT_W, default $clog2(N): code width; derived, not overridden.
- ERR_CNT_W, default 8: error counter width.

- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  block can accept a transfer this cycle.
- in_data  input  N  vector to encode.
- in_mode  input  2  encoding mode, sampled with the transfer.
- out_valid  output  1  out_code/out_err valid.
- out_ready  input  1  consumer accepts the result.
- out_code  output  OUT_W  encoded index.
- out_err  output  1  input illegal for the selected mode.
- clr_err  input  1  synchronous clear of err_count.
- err_count  output  ERR_CNT_W  saturating count of accepted transfers with err=1.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
- Modes (in_mode):
  - 2'b00 STRICT: exactly one bit set → code = its index, err = 0; otherwise code = 0, err = 1.
  - 2'b01 PRIO_HI: highest set bit index, err = 0; all-zero → code 0, err 1.
  - 2'b10 PRIO_LO: lowest set bit index, err = 0; all-zero → code 0, err 1.
  - 2'b11: reserved; behaves exactly as STRICT.
- Never drives X on any output.
- Results are written into a 2-entry FIFO: {code, err}, in order. The FIFO head drives out_code/out_err. When empty, out_code = 0 and out_err = 0.
- out_valid = (count != 0).
- in_ready is registered: next value = (count_next < 2).
- err_count increments by 1 on each input transfer whose result has err = 1. It saturates at 2^ERR_CNT_W − 1.
- clr_err forces err_count to 0 on the next edge and wins over a same-cycle increment.
- Simultaneous push and pop at count = 1: count stays 1, and the new result becomes the head on the next cycle.
- in_valid while in_ready = 0: no transfer. The source holds its data; the block does not require that.

## Timing
- Reset values (reset_n low): in_ready 0, out_valid 0, out_code 0, out_err 0, err_count 0, FIFO count 0.
- in_ready rises at the first rising edge after reset_n deasserts.
- Latency: input transfer at edge t with an empty FIFO → out_valid = 1 with the result after edge t, visible in cycle t+1.
- Throughput: 1 result per cycle while out_ready is held high.
- Backpressure: with out_ready low, two transfers fill the FIFO. in_ready falls after the edge that makes count = 2.
  - in_ready returns to 1 the cycle after the first pop.
- Full FIFO with out_ready high: the pop at edge e frees space, and in_ready = 1 after e. No same-cycle bypass of a full FIFO.
- Reset mid-operation: FIFO contents are discarded immediately (asynchronous). All outputs go to reset values without waiting for a clock edge.

## Structure
- Package prio_encoder_pkg holds:
  - typedef enum logic [1:0] enc_mode_e {ENC_STRICT, ENC_PRIO_HI, ENC_PRIO_LO, ENC_RSVD}.
  - a function returning the popcount==1 check.
- Sub-module prio_encoder_core: purely combinational, parameter N. Inputs data and mode; outputs code and err.
- The top level owns the 2-entry FIFO, the ready register and the error counter.

## Test plan
Default parameters unless stated.
- Reset/idle: hold reset_n low for 3 cycles, then release → all outputs 0 during reset; in_ready = 1 one edge after release.
- STRICT sweep: send 8'h01, 8'h02 … 8'h80 with out_ready = 1 → codes 0…7, err 0, one per cycle, each 1 cycle after acceptance.
  - Then send 8'h00 and 8'h81 → code 0, err 1 for both; err_count = 2.
- Priority modes, in_data = 8'b0101_0100:
  - PRIO_HI → code 6, err 0.
  - PRIO_LO → code 2, err 0.
  - mode 2'b11 → code 0, err 1.
- Backpressure: out_ready = 0, in_valid = 1 continuously with 8'h04, 8'h10, 8'h40.
  - in_ready drops after the second transfer; the third is held.
  - Raise out_ready → outputs 2, 4, 6 in order, with no loss or duplication.
- Error counter: N = 4, ERR_CNT_W = 2, send 5 STRICT inputs of 4'b0000 → err_count 1, 2, 3, 3, 3.
  - Assert clr_err in the same cycle as a sixth error transfer → err_count 0.
- Reset mid-stream: FIFO holds 2 entries; pulse reset_n low between edges → out_valid falls to 0 immediately; neither old entry is ever presented after reset.
